// File: rtl/gray_codec_pkg.sv
// ---------------------------------------------------------------------------
// gray_codec_pkg
//
// Purpose: shared definitions for the gray code converter pipeline.
//   - MODE_G2B / MODE_B2G : values of the per-beat mode bit
//   - gray2bin / bin2gray : conversion functions on a wide word (GW bits)
//   - hamming_exceeds_one : helper used by the optional sequence checker
//
// The functions work on a fixed GW-bit word. Callers zero-extend their K-bit
// word into it and truncate the result back to K bits. Zero upper bits do not
// disturb either conversion, so the low K result bits are exactly the K-bit
// conversion. Word widths above GW are not supported.
// ---------------------------------------------------------------------------
package gray_codec_pkg;

  localparam int GW = 64;

  localparam logic MODE_G2B = 1'b0;
  localparam logic MODE_B2G = 1'b1;

  typedef logic [GW-1:0] gword_t;

  // Binary to gray: each gray bit is the XOR of adjacent binary bits.
  function automatic gword_t bin2gray(input gword_t b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all gray bits at or above
  // it. This is built as a running XOR from the MSB downwards.
  function automatic gword_t gray2bin(input gword_t g);
    gword_t b;
    b[GW-1] = g[GW-1];
    for (int i = GW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // True when two words differ in more than one bit position.
  function automatic logic hamming_exceeds_one(input gword_t a, input gword_t b);
    return ($countones(a ^ b) > 1);
  endfunction

endpackage

// File: rtl/gray_pipe_stage.sv
// ---------------------------------------------------------------------------
// gray_pipe_stage
//
// Purpose: one register slice of the converter pipeline. It holds a valid
// bit plus the converted word and the mode tag of the beat it carries.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (clears valid and payload)
//   load     in   stage takes d_* this cycle (stage empty or being drained)
//   d_valid  in   valid bit offered by the previous stage / input
//   d_mode   in   mode tag offered with the beat
//   d_data   in   K-bit converted word offered with the beat
//   q_valid  out  stage holds a beat
//   q_mode   out  mode tag of the held beat
//   q_data   out  K-bit word of the held beat
// ---------------------------------------------------------------------------
module gray_pipe_stage #(
  parameter int K = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         d_valid,
  input  logic         d_mode,
  input  logic [K-1:0] d_data,
  output logic         q_valid,
  output logic         q_mode,
  output logic [K-1:0] q_data
);

  logic         valid_d, valid_q;
  logic         mode_d,  mode_q;
  logic [K-1:0] data_d,  data_q;

  // The payload only changes when a real beat arrives, so a bubble moving
  // through the stage leaves the previous word visible. Downstream ignores
  // it anyway because the valid bit is low.
  always_comb begin
    valid_d = valid_q;
    mode_d  = mode_q;
    data_d  = data_q;
    if (load) begin
      valid_d = d_valid;
      if (d_valid) begin
        mode_d = d_mode;
        data_d = d_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      mode_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
    end
  end

  assign q_valid = valid_q;
  assign q_mode  = mode_q;
  assign q_data  = data_q;

endmodule

// File: rtl/gray_codec_pipe.sv
// ---------------------------------------------------------------------------
// gray_codec_pipe
//
// Purpose: valid/ready pipelined gray<->binary converter. Each accepted beat
// is converted combinationally according to its own mode bit and then
// carried through STAGES register slices. The slices form an elastic
// pipeline with a combinational ready chain, so it streams one beat per
// cycle and holds up to STAGES beats under back-pressure.
//
// Parameters:
//   K       word width in bits (2 .. 64)
//   STAGES  number of register stages (>= 1), which is also the latency
//
// Ports:
//   clk             in   clock, rising edge
//   rst             in   synchronous active-high reset, flushes the pipe
//   in_valid        in   upstream beat present
//   in_ready        out  beat accepted this cycle (never while rst is high)
//   mode            in   0 = gray-to-binary, 1 = binary-to-gray
//   data_in         in   K-bit word to convert
//   out_valid       out  converted beat present
//   out_ready       in   downstream accepts the beat
//   data_out        out  K-bit converted word
//   seq_err         out  one-cycle pulse on a gray sequence violation
//   seq_err_sticky  out  latched violation flag, cleared only by reset
//
// Configuration: the seq_err / seq_err_sticky ports and the gray sequence
// checker exist only when GRAY_CODEC_SEQ_CHECK_EN is defined.
// ---------------------------------------------------------------------------
module gray_codec_pipe
  import gray_codec_pkg::*;
#(
  parameter int K      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [K-1:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] data_out
`ifdef GRAY_CODEC_SEQ_CHECK_EN
  ,
  output logic         seq_err,
  output logic         seq_err_sticky
`endif
);

  logic [K-1:0]      data_conv;
  logic              accept;

  logic [STAGES-1:0] stage_ready;
  logic [STAGES-1:0] stage_in_valid;
  logic              stage_in_mode [STAGES];
  logic [K-1:0]      stage_in_data [STAGES];
  logic [STAGES-1:0] stage_valid;
  logic              stage_mode    [STAGES];
  logic [K-1:0]      stage_data    [STAGES];

  // The mode tag of the final stage is not exported. It is kept so that every
  // slice holds the same beat record, and it is visible when debugging.
  logic              out_mode_unused;

  // Conversion sits ahead of stage 0. Later stages only move the result.
  always_comb begin
    if (mode == MODE_B2G) begin
      data_conv = K'(bin2gray(GW'(data_in)));
    end else begin
      data_conv = K'(gray2bin(GW'(data_in)));
    end
  end

  // stage_ready[s] is the ready into stage s. Stage s can load if it is
  // empty, or if everything after it will also move, which means out_ready
  // or an empty stage further down. The chain is unrolled as a running OR
  // from the output end so it has no self-referencing vector.
  always_comb begin
    logic chain;
    chain       = out_ready;
    stage_ready = '0;
    for (int s = STAGES - 1; s >= 0; s--) begin
      chain          = chain || !stage_valid[s];
      stage_ready[s] = chain;
    end
  end

  // Acceptance is blocked during reset so that no beat slips in while the
  // pipe is being flushed.
  assign in_ready = stage_ready[0] && !rst;
  assign accept   = in_valid && in_ready;

  // Stage 0 takes the freshly converted beat. Each later stage takes
  // whatever its predecessor holds, including bubbles.
  always_comb begin
    stage_in_valid[0] = accept;
    stage_in_mode[0]  = mode;
    stage_in_data[0]  = data_conv;
    for (int s = 1; s < STAGES; s++) begin
      stage_in_valid[s] = stage_valid[s-1];
      stage_in_mode[s]  = stage_mode[s-1];
      stage_in_data[s]  = stage_data[s-1];
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    gray_pipe_stage #(
      .K (K)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .load    (stage_ready[s]),
      .d_valid (stage_in_valid[s]),
      .d_mode  (stage_in_mode[s]),
      .d_data  (stage_in_data[s]),
      .q_valid (stage_valid[s]),
      .q_mode  (stage_mode[s]),
      .q_data  (stage_data[s])
    );
  end

  assign out_valid       = stage_valid[STAGES-1];
  assign data_out        = stage_data[STAGES-1];
  assign out_mode_unused = stage_mode[STAGES-1];

`ifdef GRAY_CODEC_SEQ_CHECK_EN
  // Gray sequence checker. It watches the raw input words of accepted
  // gray-to-binary beats. Consecutive gray codes may repeat or differ in one
  // bit. Anything further apart raises seq_err in the cycle after the beat is
  // accepted. The first such beat after reset only seeds the history.
  logic [K-1:0] hist_d, hist_q;
  logic         hist_valid_d, hist_valid_q;
  logic         seq_err_d, seq_err_q;
  logic         sticky_d, sticky_q;

  always_comb begin
    hist_d       = hist_q;
    hist_valid_d = hist_valid_q;
    seq_err_d    = 1'b0;
    if (accept && (mode == MODE_G2B)) begin
      if (hist_valid_q && hamming_exceeds_one(GW'(hist_q), GW'(data_in))) begin
        seq_err_d = 1'b1;
      end
      hist_d       = data_in;
      hist_valid_d = 1'b1;
    end
    sticky_d = sticky_q || seq_err_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q       <= '0;
      hist_valid_q <= 1'b0;
      seq_err_q    <= 1'b0;
      sticky_q     <= 1'b0;
    end else begin
      hist_q       <= hist_d;
      hist_valid_q <= hist_valid_d;
      seq_err_q    <= seq_err_d;
      sticky_q     <= sticky_d;
    end
  end

  assign seq_err        = seq_err_q;
  assign seq_err_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_gray_codec_pipe.sv
// ---------------------------------------------------------------------------
// tb_gray_codec_pipe
//
// Purpose: directed self-checking bench for gray_codec_pipe. One K=8,
// STAGES=2 instance covers latency, mode handling, back-pressure and
// flushing. A K=4, STAGES=1 instance walks all 16 codes in both modes.
// The sequence checker is exercised when GRAY_CODEC_SEQ_CHECK_EN is defined.
// ---------------------------------------------------------------------------
module tb_gray_codec_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid, in_ready, mode, out_valid, out_ready;
  logic [7:0] data_in, data_out;

  logic       in_valid_4, in_ready_4, mode_4, out_valid_4, out_ready_4;
  logic [3:0] data_in_4, data_out_4;

`ifdef GRAY_CODEC_SEQ_CHECK_EN
  logic       seq_err, seq_err_sticky;
  logic       seq_err_4, seq_err_sticky_4;
`endif

  int tests;
  int fails;

  // Hand-written 4-bit reference tables, indexed by the input code.
  logic [3:0] b2g_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
  logic [3:0] g2b_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h7, 4'h6, 4'h4, 4'h5,
                              4'hF, 4'hE, 4'hC, 4'hD, 4'h8, 4'h9, 4'hB, 4'hA};

  logic [7:0] stream_vec [8] = '{8'h00, 8'hFF, 8'h5A, 8'hA5,
                                 8'h01, 8'h80, 8'h3C, 8'hC5};
  logic [7:0] stall_vec  [3] = '{8'h12, 8'h34, 8'h56};
  logic [7:0] seq_vec    [4] = '{8'h00, 8'h01, 8'h03, 8'h06};

  gray_codec_pipe #(.K(8), .STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
`ifdef GRAY_CODEC_SEQ_CHECK_EN
    ,
    .seq_err        (seq_err),
    .seq_err_sticky (seq_err_sticky)
`endif
  );

  gray_codec_pipe #(.K(4), .STAGES(1)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_4),
    .in_ready  (in_ready_4),
    .mode      (mode_4),
    .data_in   (data_in_4),
    .out_valid (out_valid_4),
    .out_ready (out_ready_4),
    .data_out  (data_out_4)
`ifdef GRAY_CODEC_SEQ_CHECK_EN
    ,
    .seq_err        (seq_err_4),
    .seq_err_sticky (seq_err_sticky_4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit reference. Gray-to-binary uses a reduction XOR of the shifted
  // word for each bit position.
  function automatic logic [7:0] ref_conv(input logic m, input logic [7:0] d);
    logic [7:0] r;
    if (m) begin
      r = d ^ {1'b0, d[7:1]};
    end else begin
      for (int i = 0; i < 8; i++) begin
        r[i] = ^(d >> i);
      end
    end
    return r;
  endfunction

  // Inputs change one time unit after the rising edge. Checks happen one
  // more time unit later, so the outputs are always sampled away from the edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic m,
                               input logic [7:0] d, input logic ordy);
    in_valid  = v;
    mode      = m;
    data_in   = d;
    out_ready = ordy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    mode        = 1'b0;
    data_in     = '0;
    out_ready   = 1'b0;
    in_valid_4  = 1'b0;
    mode_4      = 1'b0;
    data_in_4   = '0;
    out_ready_4 = 1'b1;

    // Reset state
    nextCycle();
    nextCycle();
    applyStimulus(1'b1, 1'b0, 8'h11, 1'b1);
    checkOutput("in_ready_during_rst", 32'(in_ready), 32'd0);
    checkOutput("out_valid_during_rst", 32'(out_valid), 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_data_out", 32'(data_out), 32'h00);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef GRAY_CODEC_SEQ_CHECK_EN
    checkOutput("rst_seq_err", 32'(seq_err), 32'd0);
    checkOutput("rst_seq_sticky", 32'(seq_err_sticky), 32'd0);
`endif

    // Gray-to-binary C5 -> 86 with a latency of two cycles
    applyStimulus(1'b1, 1'b0, 8'hC5, 1'b1);
    checkOutput("g2b_in_ready", 32'(in_ready), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("g2b_lat1_valid", 32'(out_valid), 32'd0);
    nextCycle();
    checkOutput("g2b_lat2_valid", 32'(out_valid), 32'd1);
    checkOutput("g2b_data", 32'(data_out), 32'h86);
    nextCycle();
    checkOutput("g2b_drained", 32'(out_valid), 32'd0);

    // Binary-to-gray 86 -> C5
    applyStimulus(1'b1, 1'b1, 8'h86, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("b2g_lat1_valid", 32'(out_valid), 32'd0);
    nextCycle();
    checkOutput("b2g_lat2_valid", 32'(out_valid), 32'd1);
    checkOutput("b2g_data", 32'(data_out), 32'hC5);
    nextCycle();

    // Eight back-to-back beats with the mode alternating per beat
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        applyStimulus(1'b1, 1'(i % 2), stream_vec[i], 1'b1);
        checkOutput("stream_in_ready", 32'(in_ready), 32'd1);
      end else begin
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      end
      nextCycle();
      checkOutput("stream_valid", 32'(out_valid), 32'((i >= 1) && (i <= 8)));
      if ((i >= 1) && (i <= 8)) begin
        checkOutput("stream_data", 32'(data_out),
                    32'(ref_conv(1'((i - 1) % 2), stream_vec[i-1])));
      end
    end

    // Back-pressure: out_ready low for five cycles, two beats fit
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b1, 1'b1, stall_vec[(c < 2) ? c : 2], 1'b0);
      checkOutput("stall_in_ready", 32'(in_ready), 32'(c < 2));
      checkOutput("stall_out_valid", 32'(out_valid), 32'(c >= 2));
      if (c >= 2) begin
        checkOutput("stall_hold_data", 32'(data_out), 32'h1B);
      end
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("drain0_valid", 32'(out_valid), 32'd1);
    checkOutput("drain0_data", 32'(data_out), 32'(ref_conv(1'b1, 8'h12)));
    nextCycle();
    checkOutput("drain1_valid", 32'(out_valid), 32'd1);
    checkOutput("drain1_data", 32'(data_out), 32'(ref_conv(1'b1, 8'h34)));
    nextCycle();
    checkOutput("drain_empty", 32'(out_valid), 32'd0);
    nextCycle();
    checkOutput("drain_no_dup", 32'(out_valid), 32'd0);

    // Reset with two beats in flight
    applyStimulus(1'b1, 1'b1, 8'hAA, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 8'hBB, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("flush_full_valid", 32'(out_valid), 32'd1);
    checkOutput("flush_full_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'hCC, 1'b1);
    checkOutput("flush_rst_ready", 32'(in_ready), 32'd0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      nextCycle();
      checkOutput("flush_no_ghost", 32'(out_valid), 32'd0);
    end

`ifdef GRAY_CODEC_SEQ_CHECK_EN
    // Gray stream 00, 01, 03, 06: only the step 03 -> 06 is two bits apart
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, seq_vec[k], 1'b1);
      nextCycle();
      checkOutput("seq_err_pulse", 32'(seq_err), 32'(k == 3));
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      checkOutput("seq_err_clear", 32'(seq_err), 32'd0);
      checkOutput("seq_sticky_hold", 32'(seq_err_sticky), 32'd1);
    end
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("seq_sticky_rst", 32'(seq_err_sticky), 32'd0);
    // The first gray beat after reset must not be compared with pre-reset history
    applyStimulus(1'b1, 1'b0, 8'hF0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("seq_first_unchecked", 32'(seq_err), 32'd0);
    nextCycle();
    nextCycle();
`endif

    // Exhaustive K=4, both modes, STAGES=1
    for (int i = 0; i < 32; i++) begin
      in_valid_4  = 1'b1;
      mode_4      = (i >= 16);
      data_in_4   = 4'(i);
      out_ready_4 = 1'b1;
      #1;
      checkOutput("k4_in_ready", 32'(in_ready_4), 32'd1);
      nextCycle();
      checkOutput("k4_valid", 32'(out_valid_4), 32'd1);
      checkOutput("k4_data", 32'(data_out_4),
                  32'((i >= 16) ? b2g_tab[i % 16] : g2b_tab[i % 16]));
    end
    in_valid_4 = 1'b0;
    nextCycle();
    checkOutput("k4_drained", 32'(out_valid_4), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gray_codec_pipe.md
GRAY_CODEC_PIPE -- requirements
Module: gray_codec_pipe

Interface
REQ-001 Parameter K, default 8, word width in bits (K >= 2).
REQ-002 Parameter STAGES, default 2, pipeline register stages (STAGES >= 1).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  upstream beat present.
REQ-006 in_ready  output  1  block accepts the beat this cycle.
REQ-007 mode  input  1  per-beat conversion: 0 = gray-to-binary, 1 = binary-to-gray.
REQ-008 data_in  input  K  word to convert.
REQ-009 out_valid  output  1  converted beat present.
REQ-010 out_ready  input  1  downstream accepts the beat.
REQ-011 data_out  output  K  converted word.
REQ-012 seq_err  output  1  one-cycle pulse on a gray-sequence violation (present only with the macro in REQ-031).
REQ-013 seq_err_sticky  output  1  latched violation flag (present only with the macro in REQ-031).

Function
REQ-014 A beat SHALL transfer on input when in_valid && in_ready, and on output when out_valid && out_ready.
REQ-015 Gray-to-binary: data_out[i] SHALL equal the XOR of data_in[K-1:i] for each i.
REQ-016 Binary-to-gray: data_out SHALL equal data_in ^ (data_in >> 1).
REQ-017 mode SHALL be captured with each beat and travel with it; a mode change between beats SHALL NOT affect beats already accepted.
REQ-018 Conversion SHALL be combinational ahead of stage 0; stages 1..STAGES-1 SHALL carry the result unchanged.
REQ-019 Each stage SHALL hold a valid bit; stage i SHALL load when it is empty or its content leaves this cycle.
REQ-020 in_ready SHALL equal !v[0] || (ready into stage 1), with the ready into stage STAGES equal to out_ready (combinational ready chain).
REQ-021 With no stalls, latency SHALL be exactly STAGES cycles from input transfer to out_valid, and throughput one beat per cycle.
REQ-022 When out_ready is low, out_valid, data_out and every occupied stage SHALL hold; no beat SHALL be dropped or duplicated.
REQ-023 The pipeline SHALL hold at most STAGES beats; once full with out_ready low, in_ready SHALL be 0.
REQ-024 Simultaneous output and input transfer on a full pipeline SHALL shift all stages and accept the new beat in the same cycle.
REQ-025 data_out SHALL be don't-care while out_valid is 0.

Reset
REQ-026 On rst high at a clock edge, every stage valid bit SHALL clear, so out_valid = 0 on the following cycle.
REQ-027 After reset, data_out SHALL be 0, seq_err SHALL be 0 and seq_err_sticky SHALL be 0.
REQ-028 Reset asserted mid-stream SHALL discard all in-flight beats, and no beat SHALL be accepted in a cycle where rst is high.
REQ-029 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-030 The previous-gray history of REQ-032 SHALL be invalidated by reset.

Configuration
REQ-031 With macro GRAY_CODEC_SEQ_CHECK_EN defined, the sequence checker (REQ-032..REQ-034) and the seq_err/seq_err_sticky ports SHALL exist; without it, those ports and their logic SHALL be absent and the remaining behaviour SHALL be unchanged.
REQ-032 The checker SHALL store data_in of the last accepted mode-0 beat.
REQ-033 On each accepted mode-0 beat that has valid history, a Hamming distance from the stored word other than 0 or 1 SHALL pulse seq_err in the next cycle; the first mode-0 beat after reset SHALL NOT be checked.
REQ-034 seq_err_sticky SHALL set with seq_err and clear only on reset.

Structure
REQ-035 Shared package gray_codec_pkg SHALL hold the gray2bin and bin2gray conversion functions and the MODE_G2B and MODE_B2G constants.
REQ-036 The sub-module gray_pipe_stage (valid bit plus data/mode register with a load enable) SHALL be instantiated STAGES times.

Verification
REQ-037 K=8, STAGES=2, mode=0, data_in=8'hC5, out_ready=1 -> data_out=8'h86 with out_valid exactly 2 cycles after acceptance.
REQ-038 mode=1, data_in=8'h86 -> data_out=8'hC5; alternating the mode per beat across 8 back-to-back beats -> every result is correct at 1 beat/cycle.
REQ-039 out_ready=0 for 5 cycles while in_valid=1 -> 2 beats are accepted, then in_ready=0; releasing out_ready -> the beats emerge in order with none lost.
REQ-040 Reset asserted with 2 beats in flight -> out_valid=0 on the next cycle, and those beats never appear.
REQ-041 With the macro, the gray stream 8'h00, 8'h01, 8'h03, 8'h06 -> seq_err pulses once after 8'h06 (distance 2), and seq_err_sticky stays 1 until reset.
REQ-042 Exhaustive test with K=4: all 16 codes in each mode match the reference conversion functions.
